// File: rtl/fifo_frame_packer.sv
// Read-side FIFO drain that packs words into checksummed frames.
// Streams data + trailing checksum through a 2-entry skid buffer.
module fifo_frame_packer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic              fifo_rd_clk,
    input  logic              rst_n,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              r_fifo_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [15:0]       frame_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CSUM = 2'd2;

    localparam logic [7:0]  LAST_RD  = 8'(FRAME_LEN);
    localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [7:0]        rd_cnt;
    logic [15:0]       idle_cnt;
    logic [DATA_W-1:0] csum;
    logic              infl;
    logic              first;

    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        buf_sop;
    logic [1:0]        buf_eop;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic              pop;
    logic              cap;
    logic              csum_push;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              push_sop;
    logic              push_eop;
    logic [2:0]        level;
    logic              idle_hit;

    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_sop   = out_valid && buf_sop[rd_ptr];
    assign out_eop   = out_valid && buf_eop[rd_ptr];

    assign pop   = out_valid && out_ready;
    assign level = {1'b0, occ} + {2'b0, infl};

    // A same-cycle pop frees a slot for the word this read will return.
    assign fifo_rd_en = (state == S_DATA) && !r_fifo_empty &&
                        (rd_cnt < LAST_RD) &&
                        (level < (3'd2 + {2'b0, pop}));

    assign cap       = infl;
    assign csum_push = (state == S_CSUM) && !infl &&
                       ((occ != 2'd2) || pop);
    assign push      = cap || csum_push;
    assign push_data = cap ? fifo_rd_data : csum;
    assign push_sop  = cap && first;
    assign push_eop  = csum_push;

    // A read in the same cycle means the link is not idle.
    assign idle_hit = (idle_cnt == IDLE_MAX) && !fifo_rd_en;

    always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_cnt   <= '0;
            idle_cnt <= '0;
            csum     <= '0;
            infl     <= 1'b0;
            first    <= 1'b0;
        end else begin
            infl <= fifo_rd_en;
            if (cap) begin
                csum  <= csum + fifo_rd_data;
                first <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    rd_cnt   <= '0;
                    idle_cnt <= '0;
                    csum     <= '0;
                    first    <= 1'b1;
                    if (!r_fifo_empty) state <= S_DATA;
                end
                S_DATA: begin
                    if (fifo_rd_en) begin
                        rd_cnt   <= rd_cnt + 8'd1;
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                    if (rd_cnt == LAST_RD)
                        state <= S_CSUM;
                    else if (idle_hit)
                        state <= (rd_cnt != 8'd0) ? S_CSUM : S_IDLE;
                end
                S_CSUM: begin
                    if (csum_push) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_sop     <= '0;
            buf_eop     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= '0;
            frame_cnt   <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= push_data;
                buf_sop[wr_ptr]  <= push_sop;
                buf_eop[wr_ptr]  <= push_eop;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop && out_eop) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Bench for fifo_frame_packer: FIFO model, stream monitor and
// a frame-chunking reference model over randomized traffic.
module tb_fifo_frame_packer;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          r_fifo_empty = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [15:0]   frame_cnt;

    fifo_frame_packer #(
        .DATA_W(DW), .FRAME_LEN(FL), .TIMEOUT(TO)
    ) dut (
        .fifo_rd_clk (clk),
        .rst_n       (rst_n),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .r_fifo_empty(r_fifo_empty),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic rd_seen = 1'b0;
    int stab_err = 0;
    int empty_err = 0;
    int uflow = 0;
    logic hold = 1'b0;
    logic [17:0] held;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] words_q[$];
    logic [17:0]   beats[$];
    logic [17:0]   exp_q[$];
    int            beat_cyc[$];
    int            rd_cyc[$];

    // FIFO model: a read sampled before an edge returns data after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen) begin
                if (fifo_q.size() == 0) uflow++;
                else fifo_rd_data = fifo_q.pop_front();
            end
            r_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Drives out_ready and records transfers and reads each cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rst_n) begin
                if (hold && (!out_valid ||
                    {out_sop, out_eop, out_data} !== held))
                    stab_err++;
                if (out_valid && out_ready) begin
                    beats.push_back({out_sop, out_eop, out_data});
                    beat_cyc.push_back(cyc);
                end
                hold = out_valid && !out_ready;
                held = {out_sop, out_eop, out_data};
            end else begin
                hold = 1'b0;
            end
            #1;
            if (fifo_rd_en && r_fifo_empty) empty_err++;
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            rd_seen = fifo_rd_en;
        end
    end

    // Reference: chunk the word list into frames, append wrapped sums.
    task automatic build_exp();
        int n = 0;
        logic [DW-1:0] sum = '0;
        exp_q.delete();
        foreach (words_q[i]) begin
            exp_q.push_back({(n == 0), 1'b0, words_q[i]});
            sum = sum + words_q[i];
            n++;
            if (n == FL) begin
                exp_q.push_back({2'b01, sum});
                n = 0;
                sum = '0;
            end
        end
        if (n > 0) exp_q.push_back({2'b01, sum});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fifo_q.delete();
        repeat (3) @(negedge clk);
        beats.delete();
        beat_cyc.delete();
        rd_cyc.delete();
        stab_err = 0;
        rst_n = 1'b1;
    endtask

    task automatic push_words(input int gap);
        foreach (words_q[i]) begin
            fifo_q.push_back(words_q[i]);
            if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int b = budget;
        while (beats.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic seq_words(input int first, input int last);
        words_q.delete();
        for (int v = first; v <= last; v++) words_q.push_back(16'(v));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vec++;
        if (fifo_rd_en !== 1'b0) begin
            err++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en);
        end
        vec++;
        if (out_valid !== 1'b0) begin
            err++; $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        vec++;
        if (out_data !== 16'h0) begin
            err++; $display("FAIL rst_data: got %h want 0000", out_data);
        end
        vec++;
        if ({out_sop, out_eop} !== 2'b00) begin
            err++; $display("FAIL rst_sop_eop: got %b want 00", {out_sop, out_eop});
        end
        vec++;
        if (frame_cnt !== 16'h0) begin
            err++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt);
        end
        do_reset();
    endtask

    task automatic test_full_frame(input int mode, input string nm);
        logic [17:0] got;
        do_reset();
        ready_mode = mode;
        seq_words(1, 8);
        build_exp();
        push_words(0);
        wait_beats(exp_q.size(), 400);
        vec++;
        if (beats.size() != exp_q.size()) begin
            err++;
            $display("FAIL %s_count: got %0d want %0d", nm, beats.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < beats.size()) ? beats[i] : 'x;
            vec++;
            if (got !== exp_q[i]) begin
                err++;
                $display("FAIL %s_beat%0d: got %h want %h", nm, i, got, exp_q[i]);
            end
        end
        vec++;
        if (frame_cnt !== 16'd1) begin
            err++; $display("FAIL %s_frame_cnt: got %0d want 1", nm, frame_cnt);
        end
        vec++;
        if (stab_err !== 0) begin
            err++; $display("FAIL %s_stable: got %0d unstable holds want 0", nm, stab_err);
        end
    endtask

    task automatic test_timeout();
        logic [17:0] got;
        do_reset();
        ready_mode = 0;
        words_q = '{16'hFFFF, 16'h0002, 16'h0003};
        build_exp();
        push_words(0);
        wait_beats(4, 400);
        vec++;
        if (beats.size() != 4) begin
            err++; $display("FAIL tmo_count: got %0d want 4", beats.size());
        end
        foreach (exp_q[i]) begin
            got = (i < beats.size()) ? beats[i] : 'x;
            vec++;
            if (got !== exp_q[i]) begin
                err++; $display("FAIL tmo_beat%0d: got %h want %h", i, got, exp_q[i]);
            end
        end
        // last read, TIMEOUT idle cycles, then CSUM and one push cycle
        vec++;
        if (beats.size() < 4 || beat_cyc[3] - beat_cyc[2] != TO) begin
            err++;
            $display("FAIL tmo_gap: got %0d cycles want %0d",
                     (beats.size() < 4) ? -1 : beat_cyc[3] - beat_cyc[2], TO);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] got;
        bit ok;
        do_reset();
        ready_mode = 0;
        seq_words(1, 16);
        build_exp();
        push_words(0);
        wait_beats(18, 400);
        vec++;
        if (beats.size() != 18) begin
            err++; $display("FAIL b2b_count: got %0d want 18", beats.size());
        end
        foreach (exp_q[i]) begin
            got = (i < beats.size()) ? beats[i] : 'x;
            vec++;
            if (got !== exp_q[i]) begin
                err++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, exp_q[i]);
            end
        end
        vec++;
        if (frame_cnt !== 16'd2) begin
            err++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt);
        end
        for (int f = 0; f < 2; f++) begin
            ok = (rd_cyc.size() >= 16);
            for (int i = 1; i < FL && ok; i++)
                if (rd_cyc[f*FL+i] - rd_cyc[f*FL+i-1] != 1) ok = 0;
            vec++;
            if (!ok) begin
                err++; $display("FAIL b2b_rate%0d: got gapped reads want 1 per cycle", f);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] got;
        int b = 200;
        do_reset();
        ready_mode = 0;
        seq_words(1, 4);
        push_words(0);
        while (rd_cyc.size() < 4 && b > 0) begin
            @(negedge clk);
            b--;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({fifo_rd_en, out_valid, out_data, out_sop, out_eop, frame_cnt} !== '0) begin
            err++;
            $display("FAIL mid_rst_outputs: got %b%b %h %b%b %0d want all 0",
                     fifo_rd_en, out_valid, out_data, out_sop, out_eop, frame_cnt);
        end
        repeat (3) @(negedge clk);
        fifo_q.delete();
        beats.delete();
        beat_cyc.delete();
        rd_cyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seq_words(10, 17);
        build_exp();
        push_words(0);
        wait_beats(9, 400);
        vec++;
        if (beats.size() != 9) begin
            err++; $display("FAIL mid_count: got %0d want 9", beats.size());
        end
        foreach (exp_q[i]) begin
            got = (i < beats.size()) ? beats[i] : 'x;
            vec++;
            if (got !== exp_q[i]) begin
                err++; $display("FAIL mid_beat%0d: got %h want %h", i, got, exp_q[i]);
            end
        end
        vec++;
        if (frame_cnt !== 16'd1) begin
            err++; $display("FAIL mid_frame_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_empty_idle();
        int act = 0;
        do_reset();
        repeat (1000) begin
            @(negedge clk);
            #2;
            if (fifo_rd_en || out_valid) act++;
        end
        vec++;
        if (act !== 0) begin
            err++; $display("FAIL idle_activity: got %0d active cycles want 0", act);
        end
        vec++;
        if (frame_cnt !== 16'd0) begin
            err++; $display("FAIL idle_frame_cnt: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_random();
        logic [17:0] got;
        int n;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            ready_mode = $urandom_range(0, 1);
            n = $urandom_range(1, 30);
            words_q.delete();
            for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
            build_exp();
            push_words(8);
            wait_beats(exp_q.size(), 3000);
            vec++;
            if (beats.size() != exp_q.size()) begin
                err++;
                $display("FAIL rnd%0d_count: got %0d want %0d", it, beats.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                got = (i < beats.size()) ? beats[i] : 'x;
                vec++;
                if (got !== exp_q[i]) begin
                    err++;
                    $display("FAIL rnd%0d_beat%0d: got %h want %h", it, i, got, exp_q[i]);
                end
            end
            vec++;
            if (frame_cnt !== 16'((n + FL - 1) / FL)) begin
                err++;
                $display("FAIL rnd%0d_frame_cnt: got %0d want %0d", it, frame_cnt, (n + FL - 1) / FL);
            end
            vec++;
            if (stab_err !== 0) begin
                err++; $display("FAIL rnd%0d_stable: got %0d unstable holds want 0", it, stab_err);
            end
        end
    endtask

    task automatic test_fifo_protocol();
        vec++;
        if (empty_err !== 0) begin
            err++; $display("FAIL rd_while_empty: got %0d cycles want 0", empty_err);
        end
        vec++;
        if (uflow !== 0) begin
            err++; $display("FAIL fifo_underflow: got %0d want 0", uflow);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame(0, "frame");
        test_full_frame(1, "bp");
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_empty_idle();
        test_random();
        test_fifo_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
- Read-side consumer of the async FIFO; runs entirely in the FIFO read-clock domain.
- Drains 16-bit words from the FIFO read port and groups them into frames of FRAME_LEN data words plus one trailing checksum word.
- Presents frames on a valid/ready stream with start-of-frame and end-of-frame markers.
- Closes a partial frame after TIMEOUT idle cycles so that data never stalls inside the FIFO.

Parameters:
- DATA_W, 16: FIFO and stream word width.
- FRAME_LEN, 8: data words per full frame (range 1..255).
- TIMEOUT, 64: number of consecutive idle cycles in DATA state that closes a partial frame (range 2..65535).

Ports:
- fifo_rd_clk  in  1  clock; the FIFO read clock.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_rd_en  out  1  FIFO read strobe, one word per asserted cycle.
- fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en.
- r_fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  stream word.
- out_sop  out  1  high on the first data word of a frame.
- out_eop  out  1  high on the checksum word (last beat of a frame).
- frame_cnt  out  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0 (fifo_rd_en, out_valid, out_data, out_sop, out_eop, frame_cnt). FSM goes to IDLE. Skid buffer is emptied and all counters and the checksum are cleared. Reset mid-frame discards the partial frame; no eop is emitted for it.
- Beat transfer occurs when out_valid && out_ready.
- While out_valid && !out_ready, out_data, out_sop and out_eop hold stable.
- Output is a 2-entry skid buffer.
  - occ is the buffer occupancy; infl is 1 when a FIFO read is in flight.
  - fifo_rd_en = (state==DATA) && !r_fifo_empty && (rd_cnt < FRAME_LEN) && (occ + infl - pop < 2), where pop is a transfer in the same cycle.
  - fifo_rd_en is never asserted when r_fifo_empty is high.
  - Sustained throughput is 1 word per cycle when out_ready=1.
- FIFO read data is captured into the buffer one cycle after fifo_rd_en.
  - The first captured word of a frame carries sop.
  - Each captured word is added to csum, a DATA_W-bit sum modulo 2^DATA_W, cleared at frame start.
- FSM states:
  - IDLE: when !r_fifo_empty, go to DATA. Clear rd_cnt, csum and idle_cnt.
  - DATA:
    - rd_cnt increments on each fifo_rd_en.
    - idle_cnt increments on each cycle without fifo_rd_en and clears on each read.
    - Close the frame when rd_cnt==FRAME_LEN, or when idle_cnt==TIMEOUT-1 && rd_cnt>0, then go to CSUM.
    - If idle_cnt reaches TIMEOUT-1 with rd_cnt==0, return to IDLE with no output.
  - CSUM:
    - Wait until infl==0 and occ<2 (a same-cycle pop counts as space).
    - Push csum with eop=1, sop=0 into the buffer.
    - Go to IDLE.
- frame_cnt increments when the eop beat transfers.
- With FRAME_LEN==1, the single data word carries sop and the checksum word carries eop.
- A new frame may start reading while the previous checksum beat is still waiting in the buffer; ordering is preserved.
- r_fifo_empty rising mid-frame only stalls reads; the idle timeout governs closure.
- Overflow policy: csum wraps silently; rd_cnt never exceeds FRAME_LEN; idle_cnt saturates at TIMEOUT-1.

Test Plan:
1. FIFO preloaded with 1..8, out_ready=1 → 9 beats: 1..8 with sop on word 1, then 0x0024 with eop; frame_cnt=1; no fifo_rd_en while empty.
2. Same data, out_ready random 50% → identical 9-beat sequence with no loss or duplication. out_data, out_sop and out_eop are stable during every valid&&!ready cycle; fifo_rd_en stops when the buffer is full.
3. Three words 0xFFFF, 0x0002, 0x0003, then FIFO stays empty → after TIMEOUT=64 idle cycles: beats 0xFFFF(sop), 0x0002, 0x0003, 0x0004(eop) (checksum wrapped).
4. Continuous 16 words 1..16, out_ready=1 → two back-to-back frames with checksums 0x0024 and 0x0064; frame_cnt=2; reads run 1 per cycle within each frame.
5. rst_n pulsed low after 4 words of a frame → all outputs 0 immediately. Words 10..17 written after reset produce a fresh frame: sop on 10, checksum 0x006C.
6. r_fifo_empty held high for 1000 cycles after reset → fifo_rd_en and out_valid stay 0, frame_cnt=0.
